inst_enc: RTL and testbench
===========================

Name: inst_enc

Overview:
- Streaming RV32I instruction encoder: packs opcode, register, funct and immediate fields into a 32-bit instruction word.
- It is the inverse of the core's immediate decode path: immediates are scattered into the I/S/SB/U/UJ bit positions the decoder reads them from.
- Sits between the debug/program-loader command path and instruction memory/injection port.
- Valid/ready on both sides, buffered output, per-instruction range checking.

Parameters:
- FIFO_DEPTH, 4, output buffer entries; power of two, >=2.
- CNT_W, 16, width of encoded-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept request
- fmt  in  3  0=R 1=I 2=S 3=SB 4=U 5=UJ, 6/7 illegal
- opcode  in  7  major opcode
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field (R only)
- imm  in  32  full signed/unsigned immediate value
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer accepts word
- out_inst  out  32  encoded instruction
- out_err  out  1  word flagged: immediate out of range or illegal fmt
- enc_count  out  CNT_W  count of error-free accepted requests

Behaviour:
- Reset: rst is asynchronous, active-high.
  - While asserted: FIFO empty, out_valid=0, out_inst=0, out_err=0, enc_count=0, in_ready=0.
  - in_ready rises on the first clk edge after rst deasserts.
- Accept: request is accepted when in_valid && in_ready on a clk edge.
  - in_ready = !full, registered; there is no combinational path from out_ready to in_ready.
- Encode: combinational on the inputs; the result plus error bit is written into the FIFO on accept.
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - SB: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - UJ: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Range check: err=1 if any of the following holds.
  - I/S: imm[31:11] not all-equal.
  - SB: imm[31:12] not all-equal, or imm[0]=1.
  - U: imm[11:0]!=0.
  - UJ: imm[31:20] not all-equal, or imm[0]=1.
  - R: imm is ignored and never raises err.
- Error words: fields are still encoded with truncated bits, except illegal fmt, which encodes out_inst=0. Error words are still queued and delivered in order.
- Latency: accept at edge N gives out_valid=1 after edge N (one cycle) when the FIFO was empty.
- Output: out_inst and out_err reflect the FIFO head. The head is popped on out_valid && out_ready. out_inst must be held stable while out_valid && !out_ready.
- Full FIFO, simultaneous push and pop: in_ready was already low, so no push occurs. in_ready rises next cycle.
- Empty FIFO: out_valid=0 and out_inst holds its last value; consumers must not rely on it.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from an extra pointer bit.
- enc_count increments on each accept with err=0, wraps at 2^CNT_W-1 -> 0. It does not increment on error accepts.
- Reset mid-operation flushes all queued words; the count is lost.

Optional Feature:
- INST_ENC_ERRCNT_EN defined:
  - adds output err_count (8 bits);
  - increments on each accept with err=1 and saturates at 255;
  - resets to 0.
- Undefined: port and logic absent; out_err behaviour unchanged.

Decomposition:
- Shared package inst_pkg:
  - fmt enum (FMT_R..FMT_UJ);
  - opcode localparams (OP_IMM=7'b0010011, STORE=7'b0100011, BRANCH=7'b1100011, LUI=7'b0110111, JAL=7'b1101111, etc.);
  - packed request struct.
- One sub-module: sync_fifo (WIDTH=33, DEPTH=FIFO_DEPTH), registered full/empty.
- Encode and range check stay inline in inst_enc.

Test Plan:
- ADDI x1,x0,5 (fmt=1, op=0x13, rd=1, rs1=0, f3=0, imm=5) -> out_inst=0x00500093, out_err=0, enc_count=1, out_valid one cycle after accept.
- SW x2,8(x1) (fmt=2, op=0x23, rs1=1, rs2=2, f3=2, imm=8) -> 0x0020A423.
- BEQ x0,x0,-4 (fmt=3, op=0x63, imm=0xFFFFFFFC) -> 0xFE000EE3.
- LUI x5,0x12345000 -> 0x123452B7.
- JAL x1,+2048 -> 0x001000EF.
- ADDI with imm=2048 -> out_err=1, enc_count unchanged, err_count=1 with INST_ENC_ERRCNT_EN. SB with imm=3 -> out_err=1. fmt=7 -> out_inst=0, out_err=1.
- out_ready=0, push 6 requests -> in_ready low after 4 accepts, out_inst held stable. Release out_ready -> 4 words drain in order, then remaining 2 accepted. Assert rst mid-drain -> out_valid=0 immediately, enc_count=0.

Source files
------------

// File: rtl/inst_pkg.sv
// Shared types for the RV32I instruction encoder: format enum,
// major opcodes and the packed request bundle.
package inst_pkg;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_SB = 3'd3,
        FMT_U  = 3'd4,
        FMT_UJ = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit wrap pointers and registered
// full/empty flags.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    // Next pointers and the flags they imply after this edge.
    always_comb begin
        wr_d    = wr_q + {{AW{1'b0}}, do_push};
        rd_d    = rd_q + {{AW{1'b0}}, do_pop};
        empty_d = (wr_d == rd_d);
        full_d  = (wr_d[AW] != rd_d[AW]) &&
                  (wr_d[AW-1:0] == rd_d[AW-1:0]);
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage write; contents need no reset since empty gates use.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/inst_enc.sv
// Streaming RV32I instruction encoder with range check and output FIFO.
// Optional INST_ENC_ERRCNT_EN adds a saturating err_count output.
module inst_enc
    import inst_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count
`ifdef INST_ENC_ERRCNT_EN
   ,output logic [7:0]       err_count
`endif
);

    enc_req_t    req;
    logic [31:0] enc_inst;
    logic        enc_err;
    logic        ok11, ok12, ok20;
    logic        accept, pop;
    logic        fifo_full, fifo_empty;
    logic [32:0] head;
    logic        ready_q;
    logic [31:0] last_q;
    logic [CNT_W-1:0] cnt_q;

    assign req = {fmt, opcode, rd, rs1, rs2, funct3, funct7, imm};

    assign ok11 = (&req.imm[31:11]) | ~(|req.imm[31:11]);
    assign ok12 = (&req.imm[31:12]) | ~(|req.imm[31:12]);
    assign ok20 = (&req.imm[31:20]) | ~(|req.imm[31:20]);

    // Scatter fields into the word and flag unrepresentable immediates.
    always_comb begin
        enc_inst = '0;
        enc_err  = 1'b0;
        unique case (req.fmt)
            FMT_R: begin
                enc_inst = {req.funct7, req.rs2, req.rs1,
                            req.funct3, req.rd, req.opcode};
            end
            FMT_I: begin
                enc_inst = {req.imm[11:0], req.rs1,
                            req.funct3, req.rd, req.opcode};
                enc_err  = ~ok11;
            end
            FMT_S: begin
                enc_inst = {req.imm[11:5], req.rs2, req.rs1,
                            req.funct3, req.imm[4:0], req.opcode};
                enc_err  = ~ok11;
            end
            FMT_SB: begin
                enc_inst = {req.imm[12], req.imm[10:5], req.rs2,
                            req.rs1, req.funct3, req.imm[4:1],
                            req.imm[11], req.opcode};
                enc_err  = ~ok12 | req.imm[0];
            end
            FMT_U: begin
                enc_inst = {req.imm[31:12], req.rd, req.opcode};
                enc_err  = |req.imm[11:0];
            end
            FMT_UJ: begin
                enc_inst = {req.imm[20], req.imm[10:1], req.imm[11],
                            req.imm[19:12], req.rd, req.opcode};
                enc_err  = ~ok20 | req.imm[0];
            end
            default: begin
                enc_inst = '0;
                enc_err  = 1'b1;
            end
        endcase
    end

    assign in_ready  = ready_q & ~fifo_full;
    assign accept    = in_valid & in_ready;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;

    sync_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .data_i  ({enc_err, enc_inst}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Hold input side off until the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Keep the last delivered word visible while the FIFO is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
        end else if (pop) begin
            last_q <= head[31:0];
        end
    end

    assign out_inst = out_valid ? head[31:0] : last_q;
    assign out_err  = out_valid & head[32];

    // Count clean accepts; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && !enc_err) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign enc_count = cnt_q;

`ifdef INST_ENC_ERRCNT_EN
    logic [7:0] errc_q;

    // Saturating count of flagged accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errc_q <= '0;
        end else if (accept && enc_err && errc_q != 8'hFF) begin
            errc_q <= errc_q + 8'd1;
        end
    end

    assign err_count = errc_q;
`endif

endmodule

// File: tb/tb_inst_enc.sv
// Directed-vector bench for inst_enc.
// Define INST_ENC_ERRCNT_EN to also check err_count.
module tb_inst_enc;
    import inst_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] enc_count;
`ifdef INST_ENC_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [15:0] exp_cnt = '0;
    logic [7:0]  exp_ec  = '0;

    typedef struct {
        logic [2:0]  f;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        e;
    } vec_t;

    always #5 clk = ~clk;

    inst_enc #(
        .FIFO_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .enc_count (enc_count)
`ifdef INST_ENC_ERRCNT_EN
       ,.err_count (err_count)
`endif
    );

    function automatic vec_t mk(
        input int unsigned f, input int unsigned op,
        input int unsigned d, input int unsigned s1,
        input int unsigned s2, input int unsigned f3,
        input int unsigned f7, input logic [31:0] im,
        input logic [31:0] ex, input logic er);
        vec_t v;
        v.f   = 3'(f);
        v.op  = 7'(op);
        v.rd  = 5'(d);
        v.rs1 = 5'(s1);
        v.rs2 = 5'(s2);
        v.f3  = 3'(f3);
        v.f7  = 7'(f7);
        v.imm = im;
        v.exp = ex;
        v.e   = er;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        fmt    = v.f;
        opcode = v.op;
        rd     = v.rd;
        rs1    = v.rs1;
        rs2    = v.rs2;
        funct3 = v.f3;
        funct7 = v.f7;
        imm    = v.imm;
    endtask

    task automatic test_reset();
        #2;
        chk_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL rst_flags valid=%b ready=%b need 0 0",
                     out_valid, in_ready);
        else pass_cnt++;
        chk_cnt++;
        if (out_inst !== 32'h0 || out_err !== 1'b0)
            $display("FAIL rst_word got %h/%b need 0/0",
                     out_inst, out_err);
        else pass_cnt++;
        chk_cnt++;
        if (enc_count !== 16'h0)
            $display("FAIL rst_cnt got %0d need 0", enc_count);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_cnt++;
        if (in_ready !== 1'b0)
            $display("FAIL rst_release_ready got %b need 0", in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL rst_first_edge ready=%b valid=%b need 1 0",
                     in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_encode();
        vec_t t[$];
        int   n;
        t.push_back(mk(1, 'h13, 1, 0, 0, 0, 0, 32'h5, 32'h00500093, 0));
        t.push_back(mk(2, 'h23, 0, 1, 2, 2, 0, 32'h8, 32'h0020A423, 0));
        t.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 32'hFE000EE3, 0));
        t.push_back(mk(4, 'h37, 5, 0, 0, 0, 0, 32'h12345000, 32'h123452B7, 0));
        t.push_back(mk(5, 'h6F, 1, 0, 0, 0, 0, 32'h800, 32'h001000EF, 0));
        t.push_back(mk(0, 'h33, 3, 1, 2, 0, 0, 32'hFFFF0000, 32'h002081B3, 0));
        t.push_back(mk(0, 'h33, 3, 1, 2, 0, 'h20, 32'h0, 32'h402081B3, 0));
        t.push_back(mk(1, 'h13, 1, 0, 0, 0, 0, 32'hFFFFF800, 32'h80000093, 0));
        t.push_back(mk(1, 'h13, 1, 0, 0, 0, 0, 32'h7FF, 32'h7FF00093, 0));
        t.push_back(mk(2, 'h23, 0, 1, 2, 2, 0, 32'hFFFFFFFF, 32'hFE20AFA3, 0));
        t.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, 32'hFFE, 32'h7E000FE3, 0));
        t.push_back(mk(1, 'h13, 1, 0, 0, 0, 0, 32'h800, 32'h80000093, 1));
        t.push_back(mk(2, 'h23, 0, 1, 2, 2, 0, 32'h800, 32'h8020A023, 1));
        t.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, 32'h3, 32'h00000163, 1));
        t.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, 32'h1000, 32'h80000063, 1));
        t.push_back(mk(4, 'h37, 5, 0, 0, 0, 0, 32'h12345001, 32'h123452B7, 1));
        t.push_back(mk(5, 'h6F, 1, 0, 0, 0, 0, 32'h801, 32'h001000EF, 1));
        t.push_back(mk(5, 'h6F, 1, 0, 0, 0, 0, 32'h100000, 32'h800000EF, 1));
        t.push_back(mk(7, 'h13, 1, 0, 0, 0, 0, 32'h5, 32'h0, 1));
        t.push_back(mk(6, 'h33, 3, 1, 2, 0, 0, 32'h0, 32'h0, 1));
        foreach (t[i]) begin
            drive(t[i]);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            n = 0;
            while (!in_ready && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk_cnt++;
            if (in_ready !== 1'b1)
                $display("FAIL enc_accept_timeout vec %0d", i);
            else pass_cnt++;
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (!t[i].e) exp_cnt++;
            else if (exp_ec != 8'hFF) exp_ec++;
            chk_cnt++;
            if (out_valid !== 1'b1)
                $display("FAIL enc_latency vec %0d valid=%b need 1",
                         i, out_valid);
            else pass_cnt++;
            chk_cnt++;
            if ({out_err, out_inst} !== {t[i].e, t[i].exp})
                $display("FAIL enc_word vec %0d got %b/%h need %b/%h",
                         i, out_err, out_inst, t[i].e, t[i].exp);
            else pass_cnt++;
            chk_cnt++;
            if (enc_count !== exp_cnt)
                $display("FAIL enc_count vec %0d got %0d need %0d",
                         i, enc_count, exp_cnt);
            else pass_cnt++;
`ifdef INST_ENC_ERRCNT_EN
            chk_cnt++;
            if (err_count !== exp_ec)
                $display("FAIL err_count vec %0d got %0d need %0d",
                         i, err_count, exp_ec);
            else pass_cnt++;
`endif
            @(posedge clk); #1;
            chk_cnt++;
            if (out_valid !== 1'b0)
                $display("FAIL enc_pop vec %0d valid=%b need 0",
                         i, out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_err_flood();
        drive(mk(7, 'h13, 1, 0, 0, 0, 0, 32'h5, 32'h0, 1));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        repeat (300) @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk); #1;
        chk_cnt++;
        if (enc_count !== exp_cnt)
            $display("FAIL flood_enc_count got %0d need %0d",
                     enc_count, exp_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flood_drain valid=%b ready=%b need 0 1",
                     out_valid, in_ready);
        else pass_cnt++;
`ifdef INST_ENC_ERRCNT_EN
        chk_cnt++;
        if (err_count !== 8'hFF)
            $display("FAIL err_count_sat got %0d need 255", err_count);
        else pass_cnt++;
`endif
    endtask

    task automatic test_back_to_back();
        vec_t bw[6];
        int   popped = 0;
        int   k = 4;
        int   cyc = 0;
        logic do_pop, do_push;
        logic [31:0] got;
        for (int j = 0; j < 6; j++) begin
            bw[j] = mk(1, 'h13, j + 1, 0, 0, 0, 0,
                       32'(j * 16 + 1),
                       (32'(j * 16 + 1) << 20) | (32'(j + 1) << 7) | 32'h13,
                       0);
        end
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            drive(bw[j]);
            in_valid = 1'b1;
            chk_cnt++;
            if (in_ready !== 1'b1)
                $display("FAIL b2b_fill_ready %0d got %b need 1",
                         j, in_ready);
            else pass_cnt++;
            @(posedge clk); #1;
            exp_cnt++;
        end
        drive(bw[4]);
        chk_cnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL b2b_full ready=%b valid=%b need 0 1",
                     in_ready, out_valid);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (out_inst !== bw[0].exp || in_ready !== 1'b0)
            $display("FAIL b2b_hold got %h ready=%b need %h 0",
                     out_inst, in_ready, bw[0].exp);
        else pass_cnt++;
        chk_cnt++;
        if (enc_count !== exp_cnt)
            $display("FAIL b2b_hold_cnt got %0d need %0d",
                     enc_count, exp_cnt);
        else pass_cnt++;
        out_ready = 1'b1;
        while (popped < 6 && cyc < 40) begin
            do_pop  = out_valid;
            got     = out_inst;
            do_push = in_valid & in_ready;
            @(posedge clk); #1;
            cyc++;
            if (do_pop) begin
                chk_cnt++;
                if (got !== bw[popped].exp)
                    $display("FAIL b2b_order %0d got %h need %h",
                             popped, got, bw[popped].exp);
                else pass_cnt++;
                popped++;
            end
            if (do_push) begin
                exp_cnt++;
                k++;
                if (k < 6) drive(bw[k]);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk_cnt++;
        if (popped != 6 || k != 6)
            $display("FAIL b2b_timeout popped %0d pushed %0d need 6 6",
                     popped, k);
        else pass_cnt++;
        chk_cnt++;
        if (enc_count !== exp_cnt)
            $display("FAIL b2b_cnt got %0d need %0d", enc_count, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(mk(1, 'h13, j + 1, 0, 0, 0, 0, 32'(j), 32'h0, 0));
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk_cnt++;
        if (out_valid !== 1'b1)
            $display("FAIL mid_pre_valid got %b need 1", out_valid);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        exp_cnt = '0;
        exp_ec  = '0;
        chk_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL mid_rst_flags valid=%b ready=%b need 0 0",
                     out_valid, in_ready);
        else pass_cnt++;
        chk_cnt++;
        if (enc_count !== exp_cnt || out_inst !== 32'h0)
            $display("FAIL mid_rst_state cnt=%0d inst=%h need 0 0",
                     enc_count, out_inst);
        else pass_cnt++;
`ifdef INST_ENC_ERRCNT_EN
        chk_cnt++;
        if (err_count !== exp_ec)
            $display("FAIL mid_rst_errcnt got %0d need 0", err_count);
        else pass_cnt++;
`endif
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL mid_recover ready=%b valid=%b need 1 0",
                     in_ready, out_valid);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        fmt       = '0;
        opcode    = '0;
        rd        = '0;
        rs1       = '0;
        rs2       = '0;
        funct3    = '0;
        funct7    = '0;
        imm       = '0;
        test_reset();
        test_encode();
        test_err_flood();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
